// File: rtl/qea_loader.sv
// qea_loader: host-side sequencer for the QEA core. Loads gate context, clears the state
// RAM to |0..0>, pulses start, times the run, then streams the final state vector out.
module qea_loader #(
  parameter int PE_NUM                  = 4,
  parameter int PE_NUM_WIDTH            = 2,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int STATE_DATA_WIDTH        = 64,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter logic [STATE_DATA_WIDTH-1:0] ONE_VALUE = 64'h40000000_00000000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_cmd_start,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
  input  logic                                 i_ctx_valid,
  output logic                                 o_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
  output logic [PE_NUM-1:0]                    o_state_ena,
  output logic [PE_NUM-1:0]                    o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
  output logic                                 o_qea_start,
  input  logic                                 i_qea_complete,
  output logic                                 o_res_valid,
  input  logic                                 i_res_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_res_data,
  output logic                                 o_res_last,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err,
  output logic [31:0]                          o_cycles,
  output logic [3:0]                           o_dbg_state
);

  localparam int RES_W        = PE_NUM * STATE_DATA_WIDTH;
  localparam int GUARD_CYCLES = 2;

  typedef enum logic [3:0] {
    S_IDLE, S_CTX, S_INIT, S_START, S_RUN, S_RD_ISSUE, S_RD_WAIT, S_RD_HOLD, S_DONE
  } state_t;

  state_t                               r_state;
  logic                                 r_ctx_ready;
  logic                                 r_ctx_en;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   r_ctx_addr;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   r_ctx_data;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   r_ins_num;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   r_ctx_idx;
  logic [PE_NUM-1:0]                    r_state_en;
  logic [PE_NUM-1:0]                    r_state_we;
  logic [STATE_ADDR_WIDTH-1:0]          r_state_addr;
  logic [RES_W-1:0]                     r_state_din;
  logic [STATE_ADDR_WIDTH-1:0]          r_word;
  logic [STATE_ADDR_WIDTH-1:0]          r_last_word;
  logic                                 r_qea_start;
  logic                                 r_res_valid;
  logic [RES_W-1:0]                     r_res_data;
  logic                                 r_res_last;
  logic                                 r_busy;
  logic                                 r_done;
  logic                                 r_err;
  logic [31:0]                          r_cycles;

  logic                                 w_illegal;
  logic [MAX_QBIT_WIDTH-1:0]            w_shift;
  logic [STATE_ADDR_WIDTH-1:0]          w_last_word;
  logic [RES_W-1:0]                     w_init_word;

  assign w_illegal   = (i_qbit_num < MAX_QBIT_WIDTH'(PE_NUM_WIDTH)) ||
                       (i_qbit_num > MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH));
  assign w_shift     = i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  // N-1 as a mask; a shift of STATE_ADDR_WIDTH yields all-ones (full RAM).
  assign w_last_word = ~({STATE_ADDR_WIDTH{1'b1}} << w_shift);
  assign w_init_word = RES_W'(ONE_VALUE) << ((PE_NUM - 1) * STATE_DATA_WIDTH);

  // Handshakes (ctx and res): a word moves on a clock edge where valid and ready are both
  // high; while valid waits for ready, valid stays high and data stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ctx_ready  <= 1'b0;
      r_ctx_en     <= 1'b0;
      r_ctx_addr   <= '0;
      r_ctx_data   <= '0;
      r_ins_num    <= '0;
      r_ctx_idx    <= '0;
      r_state_en   <= '0;
      r_state_we   <= '0;
      r_state_addr <= '0;
      r_state_din  <= '0;
      r_word       <= '0;
      r_last_word  <= '0;
      r_qea_start  <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_last   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_cycles     <= '0;
    end else begin
      r_ctx_en    <= 1'b0;
      r_state_en  <= '0;
      r_state_we  <= '0;
      r_qea_start <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cmd_start) begin
            if (w_illegal) begin
              r_err  <= 1'b1;
              r_done <= 1'b1;
            end else begin
              r_err       <= 1'b0;
              r_busy      <= 1'b1;
              r_ins_num   <= i_ins_num;
              r_last_word <= w_last_word;
              r_ctx_idx   <= '0;
              r_word      <= '0;
              if (i_ins_num == '0) begin
                r_state <= S_INIT;
              end else begin
                r_state     <= S_CTX;
                r_ctx_ready <= 1'b1;
              end
            end
          end
        end
        S_CTX: begin
          if (i_ctx_valid && r_ctx_ready) begin
            r_ctx_en   <= 1'b1;
            r_ctx_addr <= r_ctx_idx;
            r_ctx_data <= i_ctx_data;
            r_ctx_idx  <= r_ctx_idx + GATE_CONTEXT_ADDR_WIDTH'(1);
            if (r_ctx_idx == r_ins_num - GATE_CONTEXT_ADDR_WIDTH'(1)) begin
              r_ctx_ready <= 1'b0;
              r_state     <= S_INIT;
            end
          end
        end
        S_INIT: begin
          r_state_en   <= '1;
          r_state_we   <= '1;
          r_state_addr <= r_word;
          r_state_din  <= (r_word == '0) ? w_init_word : '0;
          if (r_word == r_last_word) begin
            r_word  <= '0;
            r_state <= S_START;
          end else begin
            r_word <= r_word + STATE_ADDR_WIDTH'(1);
          end
        end
        S_START: begin
          r_qea_start <= 1'b1;
          r_cycles    <= '0;
          r_state     <= S_RUN;
        end
        S_RUN: begin
          // r_cycles counts from the pulse cycle, so it doubles as the complete guard.
          if (i_qea_complete && (r_cycles > 32'(GUARD_CYCLES))) begin
            r_state_en   <= '1;
            r_state_addr <= r_word;
            r_state      <= S_RD_ISSUE;
          end else if (!(&r_cycles)) begin
            r_cycles <= r_cycles + 32'd1;
          end
        end
        S_RD_ISSUE: r_state <= S_RD_WAIT;
        S_RD_WAIT: begin
          r_res_valid <= 1'b1;
          r_res_data  <= i_state_dout;
          r_res_last  <= (r_word == r_last_word);
          r_state     <= S_RD_HOLD;
        end
        S_RD_HOLD: begin
          if (r_res_valid && i_res_ready) begin
            r_res_valid <= 1'b0;
            r_res_last  <= 1'b0;
            if (r_word == r_last_word) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_word       <= r_word + STATE_ADDR_WIDTH'(1);
              r_state_en   <= '1;
              r_state_addr <= r_word + STATE_ADDR_WIDTH'(1);
              r_state      <= S_RD_ISSUE;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ctx_ready   = r_ctx_ready;
  assign o_ctx_en      = r_ctx_en;
  assign o_ctx_wea     = r_ctx_en;
  assign o_ctx_addr    = r_ctx_addr;
  assign o_ctx_data    = r_ctx_data;
  assign o_state_ena   = r_state_en;
  assign o_state_wea   = r_state_we;
  assign o_state_addra = r_state_addr;
  assign o_state_dina  = r_state_din;
  assign o_qea_start   = r_qea_start;
  assign o_res_valid   = r_res_valid;
  assign o_res_data    = r_res_data;
  assign o_res_last    = r_res_last;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_cycles      = r_cycles;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_qea_loader.sv
// tb_qea_loader: random jobs against a RAM/QEA model; context, init image, cycle count
// and readout stream are compared with values derived from the loader's rules.
module tb_qea_loader;
  localparam int PE = 4;
  localparam int DW = 64;
  localparam int RW = PE * DW;
  localparam logic [DW-1:0] ONE = 64'h40000000_00000000;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_cmd_start;
  logic [5:0]    i_qbit_num;
  logic [15:0]   i_ins_num;
  logic          i_ctx_valid;
  logic          o_ctx_ready;
  logic [63:0]   i_ctx_data;
  logic          o_ctx_en, o_ctx_wea;
  logic [15:0]   o_ctx_addr;
  logic [63:0]   o_ctx_data;
  logic [PE-1:0] o_state_ena, o_state_wea;
  logic [15:0]   o_state_addra;
  logic [RW-1:0] o_state_dina;
  logic [RW-1:0] i_state_dout;
  logic          o_qea_start;
  logic          i_qea_complete;
  logic          o_res_valid;
  logic          i_res_ready;
  logic [RW-1:0] o_res_data;
  logic          o_res_last;
  logic          o_busy, o_done, o_err;
  logic [31:0]   o_cycles;
  logic [3:0]    o_dbg_state;

  qea_loader dut (
    .clk(clk), .rst(rst), .i_cmd_start(i_cmd_start), .i_qbit_num(i_qbit_num),
    .i_ins_num(i_ins_num), .i_ctx_valid(i_ctx_valid), .o_ctx_ready(o_ctx_ready),
    .i_ctx_data(i_ctx_data), .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea),
    .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data), .o_state_ena(o_state_ena),
    .o_state_wea(o_state_wea), .o_state_addra(o_state_addra), .o_state_dina(o_state_dina),
    .i_state_dout(i_state_dout), .o_qea_start(o_qea_start), .i_qea_complete(i_qea_complete),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_data(o_res_data),
    .o_res_last(o_res_last), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_cycles(o_cycles), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_vec  = 0;
  int n_miss = 0;

  logic [RW-1:0] mem [int];
  logic [15:0]   ctx_addr_q[$];
  logic [63:0]   ctx_data_q[$];
  logic [RW-1:0] res_q[$];
  logic          last_q[$];
  logic [63:0]   ctx_words[$];
  logic [RW-1:0] exp_q[$];
  int            st_wr_cnt   = 0;
  int            ctx_total   = 0;
  int            st_total    = 0;
  int            done_cnt    = 0;
  logic          rd_pend     = 1'b0;
  logic [RW-1:0] rd_val;
  logic          prev_hold   = 1'b0;
  logic [RW-1:0] prev_data;

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] rand_word();
    logic [RW-1:0] w;
    for (int i = 0; i < RW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [RW-1:0] mem_rd(input int a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  // Monitor: samples mid-cycle, models the state RAM and records both streams.
  always @(negedge clk) begin
    if (prev_hold) begin
      check("res_hold_valid", RW'(o_res_valid), RW'(1'b1));
      check("res_hold_data", o_res_data, prev_data);
    end
    prev_hold = o_res_valid && !i_res_ready;
    prev_data = o_res_data;
    if (o_ctx_en) begin
      check("ctx_wea", RW'(o_ctx_wea), RW'(1'b1));
      ctx_addr_q.push_back(o_ctx_addr);
      ctx_data_q.push_back(o_ctx_data);
      ctx_total++;
    end
    if (o_state_ena != '0) begin
      st_total++;
      check("state_ena", RW'(o_state_ena), RW'(4'hF));
      if (o_state_wea != '0) begin
        mem[int'(o_state_addra)] = o_state_dina;
        st_wr_cnt++;
      end else begin
        rd_pend = 1'b1;
        rd_val  = mem_rd(int'(o_state_addra));
      end
    end
    if (o_res_valid && i_res_ready) begin
      res_q.push_back(o_res_data);
      last_q.push_back(o_res_last);
    end
    if (o_done) done_cnt++;
  end

  // RAM read port: data for an address seen in cycle c appears in cycle c+1; junk otherwise.
  always @(posedge clk) begin
    #1;
    if (rd_pend) begin
      i_state_dout = rd_val;
      rd_pend = 1'b0;
    end else begin
      i_state_dout = rand_word();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int q, input int n);
    i_qbit_num  = 6'(q);
    i_ins_num   = 16'(n);
    i_cmd_start = 1'b1;
    step();
    i_cmd_start = 1'b0;
  endtask

  task automatic drive_ctx(input int n, input bit gappy);
    int idx = 0;
    int g   = 0;
    bit hs;
    while (idx < n && g < 10 * n + 20) begin
      i_ctx_valid = gappy ? (g % 3 == 0) : 1'b1;
      i_ctx_data  = i_ctx_valid ? ctx_words[idx] : {$urandom, $urandom};
      hs = i_ctx_valid && o_ctx_ready;
      step();
      if (hs) idx++;
      g++;
    end
    check("ctx_accepted", RW'(idx), RW'(n));
    i_ctx_valid = 1'b0;
  endtask

  task automatic wait_start_pulse();
    int g = 0;
    i_ctx_valid = 1'b1;
    while (!o_qea_start && g < 70000) begin
      step();
      g++;
    end
    i_ctx_valid = 1'b0;
    check("start_pulse_seen", RW'(o_qea_start), RW'(1'b1));
  endtask

  task automatic clear_sb();
    ctx_addr_q.delete(); ctx_data_q.delete();
    res_q.delete(); last_q.delete();
    ctx_words.delete(); exp_q.delete();
    mem.delete();
    st_wr_cnt = 0;
  endtask

  task automatic run_job(input int q, input int n, input bit gappy, input int delay,
                         input bit glitch, input int rmode);
    int nw;
    int d0;
    int g;
    int stall;
    nw = 1 << (q - 2);
    clear_sb();
    for (int i = 0; i < n; i++) ctx_words.push_back({$urandom, $urandom});
    d0 = done_cnt;
    do_start(q, n);
    check("err_cleared_on_start", RW'(o_err), RW'(1'b0));
    check("busy_after_start", RW'(o_busy), RW'(1'b1));
    drive_ctx(n, gappy);
    wait_start_pulse();
    // Initial image: |0..0> means amplitude 1.0 in the top lane of word 0, all else zero.
    check("init_write_count", RW'(st_wr_cnt), RW'(nw));
    for (int k = 0; k < nw; k++)
      check("init_word", mem_rd(k), (k == 0) ? {ONE, {(RW - DW){1'b0}}} : '0);
    // The core "computes": replace the state RAM contents with fresh random amplitudes.
    for (int k = 0; k < nw; k++) begin
      mem[k] = rand_word();
      exp_q.push_back(mem[k]);
    end
    i_qea_complete = 1'b0;
    i_ctx_valid    = 1'b1;
    for (int c = 1; c <= delay; c++) begin
      step();
      i_qea_complete = (c == delay) || (glitch && c <= 2);
      i_cmd_start    = (c == 2);
      i_qbit_num     = 6'd1;
    end
    i_cmd_start = 1'b0;
    i_ctx_valid = 1'b0;
    g = 0;
    stall = 0;
    while (!o_done && g < nw * 20 + 100) begin
      case (rmode)
        0: i_res_ready = 1'b1;
        1: if (res_q.size() >= 5 && stall < 10) begin
             i_res_ready = 1'b0;
             stall++;
           end else begin
             i_res_ready = 1'b1;
           end
        default: i_res_ready = ($urandom_range(0, 3) != 0);
      endcase
      step();
      g++;
    end
    i_res_ready = 1'b0;
    check("done_seen", RW'(o_done), RW'(1'b1));
    check("busy_during_done", RW'(o_busy), RW'(1'b1));
    step();
    check("done_one_cycle", RW'(o_done), RW'(1'b0));
    check("busy_after_done", RW'(o_busy), RW'(1'b0));
    check("done_count", RW'(done_cnt - d0), RW'(1));
    check("ctx_write_count", RW'(ctx_addr_q.size()), RW'(n));
    for (int i = 0; i < n && i < ctx_addr_q.size(); i++) begin
      check("ctx_addr", RW'(ctx_addr_q[i]), RW'(i));
      check("ctx_data", RW'(ctx_data_q[i]), RW'(ctx_words[i]));
    end
    check("res_count", RW'(res_q.size()), RW'(nw));
    for (int i = 0; i < nw && i < res_q.size(); i++) begin
      check("res_data", res_q[i], exp_q[i]);
      check("res_last", RW'(last_q[i]), RW'(i == nw - 1));
    end
    check("cycles", RW'(o_cycles), RW'(delay));
    check("err_after_job", RW'(o_err), RW'(1'b0));
  endtask

  task automatic run_illegal(input int q);
    int ctx0 = ctx_total;
    int st0  = st_total;
    int d0   = done_cnt;
    do_start(q, 5);
    check("illegal_done", RW'(o_done), RW'(1'b1));
    check("illegal_err", RW'(o_err), RW'(1'b1));
    check("illegal_busy", RW'(o_busy), RW'(1'b0));
    i_ctx_valid = 1'b1;
    repeat (6) step();
    i_ctx_valid = 1'b0;
    check("illegal_busy_later", RW'(o_busy), RW'(1'b0));
    check("illegal_err_sticky", RW'(o_err), RW'(1'b1));
    check("illegal_ctx_strobes", RW'(ctx_total - ctx0), RW'(0));
    check("illegal_state_strobes", RW'(st_total - st0), RW'(0));
    check("illegal_done_count", RW'(done_cnt - d0), RW'(1));
  endtask

  task automatic run_reset_abort();
    int d0;
    clear_sb();
    for (int i = 0; i < 3; i++) ctx_words.push_back({$urandom, $urandom});
    do_start(5, 3);
    drive_ctx(3, 1'b0);
    wait_start_pulse();
    i_qea_complete = 1'b0;
    repeat (4) step();
    d0  = done_cnt;
    rst = 1'b1;
    step();
    check("rst_busy", RW'(o_busy), RW'(1'b0));
    check("rst_done", RW'(o_done), RW'(1'b0));
    check("rst_err", RW'(o_err), RW'(1'b0));
    check("rst_cycles", RW'(o_cycles), RW'(0));
    check("rst_ctx_ready", RW'(o_ctx_ready), RW'(1'b0));
    check("rst_ctx_en", RW'(o_ctx_en), RW'(1'b0));
    check("rst_state_ena", RW'(o_state_ena), RW'(0));
    check("rst_state_addra", RW'(o_state_addra), RW'(0));
    check("rst_qea_start", RW'(o_qea_start), RW'(1'b0));
    check("rst_res_valid", RW'(o_res_valid), RW'(1'b0));
    check("rst_res_last", RW'(o_res_last), RW'(1'b0));
    rst = 1'b0;
    repeat (5) step();
    check("rst_no_done", RW'(done_cnt - d0), RW'(0));
    check("rst_idle", RW'(o_busy), RW'(1'b0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    i_cmd_start = 1'b0; i_qbit_num = '0; i_ins_num = '0;
    i_ctx_valid = 1'b0; i_ctx_data = '0;
    i_qea_complete = 1'b0; i_res_ready = 1'b0;
    i_state_dout = '0;
    repeat (3) step();
    check("reset_busy", RW'(o_busy), RW'(1'b0));
    check("reset_done", RW'(o_done), RW'(1'b0));
    check("reset_err", RW'(o_err), RW'(1'b0));
    check("reset_cycles", RW'(o_cycles), RW'(0));
    check("reset_res_valid", RW'(o_res_valid), RW'(1'b0));
    check("reset_ctx_ready", RW'(o_ctx_ready), RW'(1'b0));
    rst = 1'b0;
    step();

    run_job(10, 865, 1'b0, 50, 1'b1, 0);
    run_job(10, 865, 1'b1, 50, 1'b0, 1);
    run_illegal(1);
    run_illegal(19);
    run_illegal(0);
    run_job(2, 0, 1'b0, 3, 1'b1, 2);
    run_reset_abort();
    run_job(4, 7, 1'b0, 20, 1'b1, 2);
    for (int j = 0; j < 4; j++)
      run_job($urandom_range(2, 6), $urandom_range(0, 40), 1'($urandom_range(0, 1)),
              $urandom_range(3, 30), 1'($urandom_range(0, 1)), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
